// File: rtl/ddr_rd_arb_if.sv
// Bundle between the DDR read arbiter and its environment: requester
// descriptors, loader data steering, DDR beat handshake, address generator.
interface ddr_rd_arb_if #(
    parameter int REQ_NUM    = 3,
    parameter int DDR_ADDR_W = 32,
    parameter int BURST_W    = 8
);
    localparam int IDW = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

    logic [REQ_NUM-1:0]                 req_valid;
    logic [REQ_NUM-1:0]                 req_ready;
    logic [REQ_NUM-1:0][DDR_ADDR_W-1:0] req_st_addr;
    logic [REQ_NUM-1:0][BURST_W-1:0]    req_burst;
    logic [REQ_NUM-1:0][DDR_ADDR_W-1:0] req_step;
    logic [REQ_NUM-1:0][BURST_W-1:0]    req_burst_num;
    logic [REQ_NUM-1:0]                 req_done;

    logic [REQ_NUM-1:0]                 cons_valid;
    logic [REQ_NUM-1:0]                 cons_ready;

    logic                               ddr_valid;
    logic                               ddr_ready;

    logic                               ag_start;
    logic [DDR_ADDR_W-1:0]              ag_st_addr;
    logic [BURST_W-1:0]                 ag_burst;
    logic [DDR_ADDR_W-1:0]              ag_step;
    logic [BURST_W-1:0]                 ag_burst_num;
    logic                               ag_done;

    logic                               busy;
    logic [IDW-1:0]                     grant_id;

    modport slave (
        input  req_valid, req_st_addr, req_burst, req_step, req_burst_num,
        input  cons_ready, ddr_valid, ag_done,
        output req_ready, req_done, cons_valid, ddr_ready,
        output ag_start, ag_st_addr, ag_burst, ag_step, ag_burst_num,
        output busy, grant_id
    );

    modport master (
        output req_valid, req_st_addr, req_burst, req_step, req_burst_num,
        output cons_ready, ddr_valid, ag_done,
        input  req_ready, req_done, cons_valid, ddr_ready,
        input  ag_start, ag_st_addr, ag_burst, ag_step, ag_burst_num,
        input  busy, grant_id
    );
endinterface

// File: rtl/ddr_rd_arb.sv
// Round-robin sharing of one DDR read channel among buffer loaders.
// Ports: clk, rst (async active-low), bus (ddr_rd_arb_if.slave).
module ddr_rd_arb #(
    parameter int REQ_NUM    = 3,
    parameter int DDR_ADDR_W = 32,
    parameter int BURST_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    ddr_rd_arb_if.slave      bus
);
    localparam int IDW = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
    localparam int CW  = 2 * BURST_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [IDW-1:0]        rr_ptr_q;
    logic [IDW-1:0]        grant_q;
    logic [CW-1:0]         cnt_q;
    logic                  addr_done_q;
    logic                  ag_start_q;
    logic                  busy_q;
    logic [REQ_NUM-1:0]    req_done_q;
    logic [DDR_ADDR_W-1:0] ag_st_addr_q;
    logic [BURST_W-1:0]    ag_burst_q;
    logic [DDR_ADDR_W-1:0] ag_step_q;
    logic [BURST_W-1:0]    ag_burst_num_q;

    logic                  win_vld;
    logic [IDW-1:0]        win_id;
    logic [IDW-1:0]        win_nxt;
    logic                  accept;
    logic [CW-1:0]         beats;
    logic [REQ_NUM-1:0]    req_ready_c;
    logic [REQ_NUM-1:0]    cons_valid_c;
    logic                  ddr_ready_c;
    logic                  xfer;
    logic [CW-1:0]         cnt_dec;
    logic                  run_last;
    logic [IDW-1:0]        done_id;

    // Scan from the highest offset down so the closest requester
    // to rr_ptr is the last (winning) assignment.
    always_comb begin : rr_search
        int idx;
        win_vld = 1'b0;
        win_id  = '0;
        idx     = 0;
        for (int k = REQ_NUM - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr_q) + k) % REQ_NUM;
            if (bus.req_valid[idx]) begin
                win_vld = 1'b1;
                win_id  = IDW'(idx);
            end
        end
    end

    assign win_nxt = (win_id == IDW'(REQ_NUM - 1)) ? '0 : win_id + 1'b1;
    assign accept  = (state_q == IDLE) && win_vld && rst;
    assign beats   = CW'(bus.req_burst[win_id]) * CW'(bus.req_burst_num[win_id]);

    always_comb begin
        req_ready_c = '0;
        if (accept)
            req_ready_c[win_id] = 1'b1;
    end

    // Steering is closed once the count is exhausted, so beats beyond
    // the descriptor are held off rather than delivered or dropped.
    always_comb begin
        cons_valid_c = '0;
        ddr_ready_c  = 1'b0;
        if (state_q == RUN && cnt_q != '0) begin
            cons_valid_c[grant_q] = bus.ddr_valid;
            ddr_ready_c           = bus.cons_ready[grant_q];
        end
    end

    assign xfer     = bus.ddr_valid && ddr_ready_c;
    assign cnt_dec  = cnt_q - CW'(xfer);
    assign run_last = (cnt_dec == '0) && (addr_done_q || bus.ag_done);
    assign done_id  = accept ? win_id : grant_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = (beats != '0) ? RUN : FIN;
            RUN:  if (run_last) state_d = FIN;
            FIN:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            rr_ptr_q       <= '0;
            grant_q        <= '0;
            cnt_q          <= '0;
            addr_done_q    <= 1'b0;
            ag_start_q     <= 1'b0;
            busy_q         <= 1'b0;
            req_done_q     <= '0;
            ag_st_addr_q   <= '0;
            ag_burst_q     <= '0;
            ag_step_q      <= '0;
            ag_burst_num_q <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= (state_d != IDLE);
            ag_start_q <= accept && (beats != '0);
            req_done_q <= '0;
            if (state_d == FIN && state_q != FIN)
                req_done_q <= REQ_NUM'(1) << done_id;
            if (accept) begin
                ag_st_addr_q   <= bus.req_st_addr[win_id];
                ag_burst_q     <= bus.req_burst[win_id];
                ag_step_q      <= bus.req_step[win_id];
                ag_burst_num_q <= bus.req_burst_num[win_id];
                grant_q        <= win_id;
                rr_ptr_q       <= win_nxt;
                cnt_q          <= beats;
                addr_done_q    <= 1'b0;
            end else begin
                if (state_q == RUN)
                    cnt_q <= cnt_dec;
                if (bus.ag_done)
                    addr_done_q <= 1'b1;
            end
        end
    end

    assign bus.req_ready    = req_ready_c;
    assign bus.req_done     = req_done_q;
    assign bus.cons_valid   = cons_valid_c;
    assign bus.ddr_ready    = ddr_ready_c;
    assign bus.ag_start     = ag_start_q;
    assign bus.ag_st_addr   = ag_st_addr_q;
    assign bus.ag_burst     = ag_burst_q;
    assign bus.ag_step      = ag_step_q;
    assign bus.ag_burst_num = ag_burst_num_q;
    assign bus.busy         = busy_q;
    assign bus.grant_id     = grant_q;
endmodule

// File: tb/tb_ddr_rd_arb.sv
// Directed bench for ddr_rd_arb: arbitration, steering, retire timing.
// Drives at the falling edge, checks 1 ns later.
module tb_ddr_rd_arb;
    localparam int RN = 3;
    localparam int AW = 32;
    localparam int BW = 8;

    logic clk = 1'b0;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   hs;

    ddr_rd_arb_if #(.REQ_NUM(RN), .DDR_ADDR_W(AW), .BURST_W(BW)) bif ();

    ddr_rd_arb #(.REQ_NUM(RN), .DDR_ADDR_W(AW), .BURST_W(BW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] oh(input int i);
        return 64'(1) << i;
    endfunction

    task automatic set_req(input int i, input logic [AW-1:0] a,
                           input logic [BW-1:0] b, input logic [AW-1:0] s,
                           input logic [BW-1:0] n);
        bif.req_st_addr[i]   = a;
        bif.req_burst[i]     = b;
        bif.req_step[i]      = s;
        bif.req_burst_num[i] = n;
    endtask

    initial begin
        rst               = 1'b0;
        bif.req_valid     = '0;
        bif.req_st_addr   = '0;
        bif.req_burst     = '0;
        bif.req_step      = '0;
        bif.req_burst_num = '0;
        bif.cons_ready    = '0;
        bif.ddr_valid     = 1'b0;
        bif.ag_done       = 1'b0;

        // reset state
        @(negedge clk); #1;
        chk("rst_busy", 64'(bif.busy), 64'd0);
        chk("rst_start", 64'(bif.ag_start), 64'd0);
        chk("rst_gid", 64'(bif.grant_id), 64'd0);
        chk("rst_addr", 64'(bif.ag_st_addr), 64'd0);
        chk("rst_done", 64'(bif.req_done), 64'd0);
        chk("rst_ready", 64'(bif.req_ready), 64'd0);
        rst = 1'b1;

        // withdrawn request: shown ready, no grant
        @(negedge clk);
        bif.req_valid = 3'b100;
        #1;
        chk("wd_ready", 64'(bif.req_ready), 64'h4);
        #2;
        bif.req_valid = 3'b000;
        @(negedge clk); #1;
        chk("wd_busy", 64'(bif.busy), 64'd0);
        chk("wd_start", 64'(bif.ag_start), 64'd0);

        // round robin from reset pointer: 0,1,2,0
        set_req(0, 32'h100, 8'd1, 32'h0, 8'd1);
        set_req(1, 32'h200, 8'd1, 32'h0, 8'd1);
        set_req(2, 32'h300, 8'd1, 32'h0, 8'd1);
        bif.cons_ready = 3'b111;
        for (int k = 0; k < 4; k++) begin
            int g;
            g = k % 3;
            @(negedge clk);
            bif.req_valid = 3'b111;
            #1;
            chk("rr_ready", 64'(bif.req_ready), oh(g));
            chk("rr_idle", 64'(bif.busy), 64'd0);
            @(negedge clk);
            bif.ddr_valid = 1'b1;
            bif.ag_done   = 1'b1;
            #1;
            chk("rr_gid", 64'(bif.grant_id), 64'(g));
            chk("rr_start", 64'(bif.ag_start), 64'd1);
            chk("rr_addr", 64'(bif.ag_st_addr), 64'(32'h100 * (g + 1)));
            chk("rr_cvalid", 64'(bif.cons_valid), oh(g));
            chk("rr_noready", 64'(bif.req_ready), 64'd0);
            @(negedge clk);
            bif.ddr_valid = 1'b0;
            bif.ag_done   = 1'b0;
            #1;
            chk("rr_done", 64'(bif.req_done), oh(g));
            chk("rr_fin_ready", 64'(bif.req_ready), 64'd0);
        end
        @(negedge clk);
        bif.req_valid = 3'b000;

        // single 4x2 transfer to req1 (rr_ptr now 1)
        @(negedge clk);
        bif.req_valid = 3'b010;
        set_req(1, 32'h1000, 8'd4, 32'h40, 8'd2);
        #1;
        chk("s_ready", 64'(bif.req_ready), 64'h2);
        hs = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bif.req_valid = 3'b000;
            bif.ddr_valid = 1'b1;
            bif.ag_done   = (i == 7);
            #1;
            if (bif.ddr_valid && bif.ddr_ready) hs++;
            if (i == 0) begin
                chk("s_start", 64'(bif.ag_start), 64'd1);
                chk("s_busy", 64'(bif.busy), 64'd1);
                chk("s_addr", 64'(bif.ag_st_addr), 64'h1000);
                chk("s_burst", 64'(bif.ag_burst), 64'd4);
                chk("s_step", 64'(bif.ag_step), 64'h40);
                chk("s_bnum", 64'(bif.ag_burst_num), 64'd2);
                chk("s_gid", 64'(bif.grant_id), 64'd1);
            end
            if (i == 1) chk("s_start1", 64'(bif.ag_start), 64'd0);
            chk("s_cvalid", 64'(bif.cons_valid), 64'h2);
            chk("s_dready", 64'(bif.ddr_ready), 64'd1);
        end
        @(negedge clk);
        bif.ddr_valid = 1'b0;
        bif.ag_done   = 1'b0;
        #1;
        chk("s_done", 64'(bif.req_done), 64'h2);
        chk("s_finbusy", 64'(bif.busy), 64'd1);
        chk("s_beats", 64'(hs), 64'd8);
        @(negedge clk); #1;
        chk("s_idle", 64'(bif.busy), 64'd0);
        chk("s_done0", 64'(bif.req_done), 64'd0);

        // back-pressure on req2, 4 beats, ready toggling 1010...
        @(negedge clk);
        bif.req_valid = 3'b100;
        set_req(2, 32'h2000, 8'd4, 32'h10, 8'd1);
        #1;
        chk("bp_ready", 64'(bif.req_ready), 64'h4);
        hs = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            bif.req_valid  = 3'b000;
            bif.ddr_valid  = 1'b1;
            bif.cons_ready = (i % 2 == 0) ? 3'b100 : 3'b000;
            bif.ag_done    = (i == 1);
            #1;
            if (bif.ddr_valid && bif.ddr_ready) hs++;
            chk("bp_dready", 64'(bif.ddr_ready), 64'(i % 2 == 0));
            chk("bp_cvalid", 64'(bif.cons_valid), 64'h4);
        end
        @(negedge clk);
        bif.ag_done = 1'b0;
        #1;
        chk("bp_done", 64'(bif.req_done), 64'h4);
        chk("bp_fin_dready", 64'(bif.ddr_ready), 64'd0);
        chk("bp_fin_cvalid", 64'(bif.cons_valid), 64'd0);
        chk("bp_beats", 64'(hs), 64'd4);
        bif.ddr_valid  = 1'b0;
        bif.cons_ready = 3'b111;
        @(negedge clk); #1;
        chk("bp_idle", 64'(bif.busy), 64'd0);

        // zero-length descriptor on req0
        @(negedge clk);
        bif.req_valid = 3'b001;
        set_req(0, 32'h3000, 8'd3, 32'h8, 8'd0);
        #1;
        chk("z_ready", 64'(bif.req_ready), 64'h1);
        @(negedge clk);
        bif.req_valid = 3'b000;
        #1;
        chk("z_start", 64'(bif.ag_start), 64'd0);
        chk("z_done", 64'(bif.req_done), 64'h1);
        chk("z_busy", 64'(bif.busy), 64'd1);
        @(negedge clk); #1;
        chk("z_done0", 64'(bif.req_done), 64'd0);
        chk("z_idle", 64'(bif.busy), 64'd0);
        chk("z_start0", 64'(bif.ag_start), 64'd0);

        // late ag_done on req1, 2 beats
        @(negedge clk);
        bif.req_valid = 3'b010;
        set_req(1, 32'h4000, 8'd2, 32'h20, 8'd1);
        #1;
        chk("l_ready", 64'(bif.req_ready), 64'h2);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bif.req_valid = 3'b000;
            bif.ddr_valid = 1'b1;
            #1;
            chk("l_dready", 64'(bif.ddr_ready), 64'd1);
        end
        for (int j = 0; j < 4; j++) begin
            @(negedge clk); #1;
            chk("l_hold_dready", 64'(bif.ddr_ready), 64'd0);
            chk("l_hold_cvalid", 64'(bif.cons_valid), 64'd0);
            chk("l_hold_done", 64'(bif.req_done), 64'd0);
        end
        @(negedge clk);
        bif.ag_done = 1'b1;
        #1;
        chk("l_ag_dready", 64'(bif.ddr_ready), 64'd0);
        chk("l_ag_busy", 64'(bif.busy), 64'd1);
        @(negedge clk);
        bif.ag_done   = 1'b0;
        bif.ddr_valid = 1'b0;
        #1;
        chk("l_done", 64'(bif.req_done), 64'h2);
        @(negedge clk); #1;
        chk("l_idle", 64'(bif.busy), 64'd0);

        // reset mid-RUN (rr_ptr now 2, only req1 valid)
        @(negedge clk);
        bif.req_valid = 3'b010;
        set_req(1, 32'h5000, 8'd4, 32'h40, 8'd2);
        #1;
        chk("r_ready", 64'(bif.req_ready), 64'h2);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bif.req_valid = 3'b000;
            bif.ddr_valid = 1'b1;
            #1;
            chk("r_dready", 64'(bif.ddr_ready), 64'd1);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("r_busy", 64'(bif.busy), 64'd0);
        chk("r_start", 64'(bif.ag_start), 64'd0);
        chk("r_addr", 64'(bif.ag_st_addr), 64'd0);
        chk("r_burst", 64'(bif.ag_burst), 64'd0);
        chk("r_gid", 64'(bif.grant_id), 64'd0);
        chk("r_done", 64'(bif.req_done), 64'd0);
        chk("r_cvalid", 64'(bif.cons_valid), 64'd0);
        chk("r_dready", 64'(bif.ddr_ready), 64'd0);
        @(negedge clk); #1;
        chk("r_done_hold", 64'(bif.req_done), 64'd0);
        rst           = 1'b1;
        bif.ddr_valid = 1'b0;
        @(negedge clk);
        bif.req_valid = 3'b111;
        set_req(0, 32'h100, 8'd1, 32'h0, 8'd1);
        set_req(1, 32'h200, 8'd1, 32'h0, 8'd1);
        set_req(2, 32'h300, 8'd1, 32'h0, 8'd1);
        #1;
        chk("r_next_ready", 64'(bif.req_ready), 64'h1);
        chk("r_no_restart", 64'(bif.ag_start), 64'd0);
        chk("r_post_done", 64'(bif.req_done), 64'd0);
        chk("r_post_busy", 64'(bif.busy), 64'd0);
        @(negedge clk);
        bif.req_valid = 3'b000;
        bif.ddr_valid = 1'b1;
        bif.ag_done   = 1'b1;
        #1;
        chk("r_next_gid", 64'(bif.grant_id), 64'd0);
        chk("r_next_start", 64'(bif.ag_start), 64'd1);
        chk("r_next_addr", 64'(bif.ag_st_addr), 64'h100);
        chk("r_next_cvalid", 64'(bif.cons_valid), 64'h1);
        @(negedge clk);
        bif.ddr_valid = 1'b0;
        bif.ag_done   = 1'b0;
        #1;
        chk("r_next_done", 64'(bif.req_done), 64'h1);
        @(negedge clk); #1;
        chk("r_end_idle", 64'(bif.busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/ddr_rd_arb.md
# ddr_rd_arb

Round-robin arbiter and sequencer that shares one DDR read channel (one `ddr_addr_gen` instance plus its returning data stream) among several buffer loaders, e.g. the index, partial-sum and accum/bias loaders on DDR port 2. It accepts one transfer descriptor at a time from the requesters, configures and starts the address generator, and steers each data beat's valid/ready to the granted loader. It counts beats and retires the transfer before granting the next requester.

## Interface
- `REQ_NUM`, 3, number of requesters
- `DDR_ADDR_W`, 32, DDR address width
- `BURST_W`, 8, burst length / burst count width
- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active-low reset (one clock; polarity and synchronicity fixed)
- `req_valid`  in  REQ_NUM  descriptor valid per requester
- `req_ready`  out  REQ_NUM  one-hot grant; descriptor accepted when `req_valid[i] & req_ready[i]`
- `req_st_addr`  in  REQ_NUM×DDR_ADDR_W  start address
- `req_burst`  in  REQ_NUM×BURST_W  beats per burst
- `req_step`  in  REQ_NUM×DDR_ADDR_W  address stride between bursts
- `req_burst_num`  in  REQ_NUM×BURST_W  number of bursts
- `req_done`  out  REQ_NUM  1-cycle pulse when the requester's transfer retires
- `cons_valid`  out  REQ_NUM  data valid steered to the granted loader
- `cons_ready`  in  REQ_NUM  loader ready
- `ddr_valid`  in  1  DDR data beat valid
- `ddr_ready`  out  1  DDR data beat ready
- `ag_start`  out  1  1-cycle start pulse to the address generator
- `ag_st_addr` / `ag_burst` / `ag_step` / `ag_burst_num`  out  DDR_ADDR_W / BURST_W / DDR_ADDR_W / BURST_W  registered descriptor
- `ag_done`  in  1  1-cycle pulse: all addresses issued
- `busy`  out  1  high in every state except IDLE
- `grant_id`  out  $clog2(REQ_NUM)  index of the current or last grant

## Operation
- States:
  - IDLE: no transfer in progress; arbitration is active.
  - RUN: transfer started; data is being steered and counted.
  - FIN: retire cycle.
- IDLE:
  - If any `req_valid` is set, assert `req_ready[g]` combinationally for the round-robin winner `g`.
  - Search order starts at `rr_ptr`, wraps modulo REQ_NUM.
  - Only one bit of `req_ready` is ever set.
- Accept in IDLE:
  - Register the descriptor into `ag_*` and set `grant_id = g`, `rr_ptr = (g+1) mod REQ_NUM`.
  - Compute `beats = burst * burst_num`, width 2·BURST_W, no truncation.
  - If `beats != 0`: go to RUN and pulse `ag_start` for one cycle.
  - If `beats == 0`: go to FIN, no `ag_start`.
- RUN:
  - `cons_valid[grant_id] = ddr_valid`; all other `cons_valid` bits are 0.
  - `ddr_ready = cons_ready[grant_id]`.
  - A beat transfers when `ddr_valid & ddr_ready`; the beat counter decrements on each transfer.
  - `addr_done` is a sticky flag, set by `ag_done` and cleared on accept.
  - Exit to FIN when the counter is 0 and either `addr_done` is set or `ag_done` is high in the same cycle.
- FIN: pulse `req_done[grant_id]`, then go to IDLE.
- Outside RUN: `ddr_ready = 0`, all `cons_valid = 0`; stray DDR beats are back-pressured and never dropped silently.
- Concurrent `ag_done` and last beat in the same cycle: retire normally.
- `ag_done` arriving after the last beat: stay in RUN with `ddr_ready = 0` until `ag_done`.
- Requester deasserting `req_valid` before it is accepted: legal, and no grant results.

## Timing
- Reset (`rst` low, asynchronous):
  - State IDLE; `rr_ptr = 0`; `grant_id = 0`; counter 0; `addr_done = 0`.
  - `ag_*` outputs 0; `ag_start`, `req_done`, `busy` all 0.
  - Reset mid-transfer aborts the transfer immediately: no `req_done`, and the address generator is not restarted.
- Accept at cycle N:
  - `ag_start` and `busy` are high at N+1.
  - The first beat can be steered at N+1.
- Last beat at M with `addr_done` already set:
  - FIN at M+1 (`req_done` pulse, `busy` still high).
  - IDLE at M+2; the next `req_ready` can appear at M+2.
- Zero-beat descriptor accepted at N: `req_done` at N+1, IDLE at N+2.
- `req_ready`, `cons_valid` and `ddr_ready` are combinational from registered state plus inputs. All other outputs are registered.

## Test plan
- **Single transfer:**
  - Stimulus: req1 with addr 0x1000, burst 4, step 0x40, burst_num 2; `cons_ready` = 1.
  - Expected: one `ag_start` with those values; 8 beats steered only to `cons_valid[1]`; `req_done[1]` one cycle after the 8th beat and `ag_done`.
- **Round robin:**
  - Stimulus: req0/1/2 held valid continuously, each with burst 1, burst_num 1.
  - Expected: grants in order 1? No — from reset: 0, 1, 2, 0; `grant_id` follows; never two grants overlapping.
- **Back-pressure:**
  - Stimulus: `cons_ready[2]` toggled 1010 during a 4-beat transfer.
  - Expected: `ddr_ready` mirrors it; exactly 4 handshakes counted; no beat lost.
- **Zero length:**
  - Stimulus: req0 with burst_num 0.
  - Expected: no `ag_start`; `req_done[0]` at N+1.
- **Late `ag_done`:**
  - Stimulus: `ag_done` 5 cycles after the last beat.
  - Expected: `req_done` exactly one cycle after `ag_done`; `ddr_ready` = 0 meanwhile.
- **Reset mid-RUN:**
  - Stimulus: assert `rst` low after beat 2 of 8, then release.
  - Expected: all outputs 0 during reset; no `req_done`; next grant goes to req0 under the reset-value `rr_ptr`.
